cpu_bus_arbiter: RTL and testbench

- Shares the single CPU memory bus between the instruction fetch port (instruction cache miss path) and the data port (load/store unit or data cache).
- Round-robin arbitration, with the grant held for a whole request/ready transaction.
- A watchdog terminates transactions the bus never acknowledges, so the pipeline cannot hang.
- Sits between the CPU core ports and the system bus / interconnect.

---
 rtl/cpu_bus_arbiter_pkg.sv | 23 ++
 rtl/cpu_bus_arbiter_if.sv | 51 +++++
 rtl/cpu_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared CPU bus definitions: FSM state encodings, port identifiers and
// watchdog defaults used by the arbiter and anything that decodes its state.
// No logic, so no latency and no backpressure.
package cpu_bus_arbiter_pkg;

  // FSM states; the numeric encoding is fixed so debug tooling can decode it.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } state_e;

  // Requesting port identifiers, also used for the round-robin history bit.
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Default watchdog limit and a counter width wide enough to reach it.
  localparam int unsigned DEFAULT_TIMEOUT   = 1024;
  localparam int unsigned DEFAULT_TIMEOUT_W = 11;

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// Signal bundle for the CPU bus arbiter: instruction port, data port,
// downstream system bus and the sticky watchdog flag.
// master = arbiter view (drives o_*), slave = environment view (drives i_*).
interface cpu_bus_arbiter_if;

  // Instruction fetch port
  logic        i_ibus_request;
  logic [31:0] i_ibus_address;
  logic [31:0] o_ibus_rdata;
  logic        o_ibus_ready;

  // Data port
  logic        i_dbus_request;
  logic        i_dbus_rw;
  logic [31:0] i_dbus_address;
  logic [31:0] i_dbus_wdata;
  logic [31:0] o_dbus_rdata;
  logic        o_dbus_ready;

  // Downstream system bus
  logic        o_bus_request;
  logic        o_bus_rw;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;

  // Watchdog status
  logic        o_timeout;

  modport master (
    input  i_ibus_request, i_ibus_address,
    input  i_dbus_request, i_dbus_rw, i_dbus_address, i_dbus_wdata,
    input  i_bus_ready, i_bus_rdata,
    output o_ibus_rdata, o_ibus_ready,
    output o_dbus_rdata, o_dbus_ready,
    output o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
    output o_timeout
  );

  modport slave (
    output i_ibus_request, i_ibus_address,
    output i_dbus_request, i_dbus_rw, i_dbus_address, i_dbus_wdata,
    output i_bus_ready, i_bus_rdata,
    input  o_ibus_rdata, o_ibus_ready,
    input  o_dbus_rdata, o_dbus_ready,
    input  o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
    input  o_timeout
  );

endinterface

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter sharing one CPU memory bus between the I and D ports,
// with a watchdog that force-completes transactions the bus never acknowledges.
// Latency: grant takes effect one cycle after request; ready is combinational from i_bus_ready.
// Backpressure: a port waits (request held) while the other owns the bus; the owner waits on i_bus_ready.
// Ports: i_clock, i_reset (async active-low), bus (master modport: I/D ports,
//        downstream bus, o_timeout sticky flag).
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int unsigned TIMEOUT_W = DEFAULT_TIMEOUT_W
) (
  input  logic               i_clock,
  input  logic               i_reset,
  cpu_bus_arbiter_if.master  bus
);

  localparam bit WDOG_EN = (TIMEOUT != 0);
  // Last counter value before expiry; guarded so TIMEOUT=0 does not underflow.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST =
    TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e               state_q, state_d;
  port_e                last_grant_q, last_grant_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;

  logic                 sel_d;
  logic                 g_req;
  port_e                g_port;
  logic                 expire;
  logic                 ready;
  logic [31:0]          rdata;

  assign sel_d  = (state_q == ST_GRANT_D);
  assign g_req  = sel_d ? bus.i_dbus_request : bus.i_ibus_request;
  assign g_port = sel_d ? PORT_D : PORT_I;
  // Expiry only matters when no bus ready arrives; the if-chain below gives
  // a real completion priority over the watchdog.
  assign expire = WDOG_EN && (cnt_q == CNT_LAST);

  assign bus.o_timeout = timeout_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    timeout_d    = timeout_q;
    ready        = 1'b0;
    rdata        = '0;

    bus.o_bus_request = 1'b0;
    bus.o_bus_rw      = 1'b0;
    bus.o_bus_address = '0;
    bus.o_bus_wdata   = '0;
    bus.o_ibus_ready  = 1'b0;
    bus.o_ibus_rdata  = '0;
    bus.o_dbus_ready  = 1'b0;
    bus.o_dbus_rdata  = '0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.i_ibus_request && bus.i_dbus_request)
          state_d = (last_grant_q == PORT_D) ? ST_GRANT_I : ST_GRANT_D;
        else if (bus.i_ibus_request)
          state_d = ST_GRANT_I;
        else if (bus.i_dbus_request)
          state_d = ST_GRANT_D;
      end

      ST_GRANT_I, ST_GRANT_D: begin
        bus.o_bus_request = g_req;
        // The I port never drives rw or wdata, so it can never write.
        if (sel_d) begin
          bus.o_bus_address = bus.i_dbus_address;
          bus.o_bus_rw      = bus.i_dbus_rw;
          bus.o_bus_wdata   = bus.i_dbus_wdata;
        end else begin
          bus.o_bus_address = bus.i_ibus_address;
        end

        if (bus.i_bus_ready) begin
          state_d      = ST_IDLE;
          last_grant_d = g_port;
        end else if (!g_req) begin
          // Abort: requester gave up, history untouched.
          state_d = ST_IDLE;
        end else if (expire) begin
          state_d      = ST_IDLE;
          last_grant_d = g_port;
          timeout_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        ready = g_req && (bus.i_bus_ready || expire);
        rdata = (g_req && bus.i_bus_ready) ? bus.i_bus_rdata : '0;
        if (sel_d) begin
          bus.o_dbus_ready = ready;
          bus.o_dbus_rdata = rdata;
        end else begin
          bus.o_ibus_ready = ready;
          bus.o_ibus_rdata = rdata;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Async reset forces IDLE, which zeroes every combinational output at once.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_D;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter with an 8-cycle watchdog.
// Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_cpu_bus_arbiter;

  logic i_clock;
  logic i_reset;
  int   n_vec;
  int   n_err;
  logic is_d;

  cpu_bus_arbiter_if bif ();

  cpu_bus_arbiter #(.TIMEOUT(8), .TIMEOUT_W(4)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bif)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    i_reset = 1'b0;
    bif.i_ibus_request = 1'b0;
    bif.i_ibus_address = '0;
    bif.i_dbus_request = 1'b0;
    bif.i_dbus_rw      = 1'b0;
    bif.i_dbus_address = '0;
    bif.i_dbus_wdata   = '0;
    bif.i_bus_ready    = 1'b0;
    bif.i_bus_rdata    = '0;

    // Reset state
    repeat (2) @(negedge i_clock);
    #1;
    chk("rst_bus_req", bif.o_bus_request, 0);
    chk("rst_iready", bif.o_ibus_ready, 0);
    chk("rst_dready", bif.o_dbus_ready, 0);
    chk("rst_timeout", bif.o_timeout, 0);
    chk("rst_addr", bif.o_bus_address, 0);
    @(negedge i_clock); i_reset = 1'b1;

    // T1: I only, ready on third granted cycle
    @(negedge i_clock); bif.i_ibus_request = 1'b1; bif.i_ibus_address = 32'h0000_1000; #1;
    chk("t1_idle_req", bif.o_bus_request, 0);
    @(negedge i_clock); #1;
    chk("t1_g1_req", bif.o_bus_request, 1);
    chk("t1_g1_addr", bif.o_bus_address, 32'h0000_1000);
    chk("t1_g1_rw", bif.o_bus_rw, 0);
    chk("t1_g1_iready", bif.o_ibus_ready, 0);
    @(negedge i_clock); #1;
    chk("t1_g2_req", bif.o_bus_request, 1);
    @(negedge i_clock); bif.i_bus_ready = 1'b1; bif.i_bus_rdata = 32'hDEAD_BEEF; #1;
    chk("t1_iready", bif.o_ibus_ready, 1);
    chk("t1_irdata", bif.o_ibus_rdata, 32'hDEAD_BEEF);
    chk("t1_dready", bif.o_dbus_ready, 0);
    chk("t1_rw", bif.o_bus_rw, 0);
    @(negedge i_clock); bif.i_bus_ready = 1'b0; bif.i_bus_rdata = '0; bif.i_ibus_request = 1'b0; #1;
    chk("t1_after_req", bif.o_bus_request, 0);
    chk("t1_after_iready", bif.o_ibus_ready, 0);

    // Reset pulse so round-robin history starts from D again
    @(negedge i_clock); i_reset = 1'b0;
    @(negedge i_clock); i_reset = 1'b1;

    // T2: both ports held, expect I, D, I, D with an idle gap between each
    @(negedge i_clock);
    bif.i_ibus_request = 1'b1; bif.i_ibus_address = 32'h0000_2000;
    bif.i_dbus_request = 1'b1; bif.i_dbus_rw = 1'b1;
    bif.i_dbus_address = 32'h0000_0020; bif.i_dbus_wdata = 32'h55AA_55AA;
    #1;
    chk("t2_idle0_req", bif.o_bus_request, 0);
    for (int k = 0; k < 4; k++) begin
      is_d = k[0];
      @(negedge i_clock); bif.i_bus_ready = 1'b0; #1;
      chk("t2_req", bif.o_bus_request, 1);
      chk("t2_addr", bif.o_bus_address, is_d ? 32'h0000_0020 : 32'h0000_2000);
      chk("t2_rw", bif.o_bus_rw, {31'd0, is_d});
      chk("t2_wdata", bif.o_bus_wdata, is_d ? 32'h55AA_55AA : 32'h0);
      @(negedge i_clock); bif.i_bus_ready = 1'b1; bif.i_bus_rdata = 32'hA000_0000 + k; #1;
      chk("t2_iready", bif.o_ibus_ready, {31'd0, !is_d});
      chk("t2_dready", bif.o_dbus_ready, {31'd0, is_d});
      chk("t2_rdata", is_d ? bif.o_dbus_rdata : bif.o_ibus_rdata, 32'hA000_0000 + k);
      chk("t2_other_rdata", is_d ? bif.o_ibus_rdata : bif.o_dbus_rdata, 32'h0);
      @(negedge i_clock); bif.i_bus_ready = 1'b0; bif.i_bus_rdata = '0;
      if (k == 3) begin bif.i_ibus_request = 1'b0; bif.i_dbus_request = 1'b0; end
      #1;
      chk("t2_gap_req", bif.o_bus_request, 0);
      chk("t2_gap_iready", bif.o_ibus_ready, 0);
      chk("t2_gap_dready", bif.o_dbus_ready, 0);
    end

    // Quick I transaction so history points at I before the watchdog test
    @(negedge i_clock); bif.i_ibus_request = 1'b1; bif.i_ibus_address = 32'h0000_3000;
    @(negedge i_clock); bif.i_bus_ready = 1'b1; bif.i_bus_rdata = 32'h1111_1111; #1;
    chk("t3p_iready", bif.o_ibus_ready, 1);

    // T3: D granted, bus never ready, expiry on 8th granted cycle
    @(negedge i_clock);
    bif.i_bus_ready = 1'b0; bif.i_bus_rdata = 32'hBAD0_BAD0; bif.i_ibus_request = 1'b0;
    bif.i_dbus_request = 1'b1; bif.i_dbus_rw = 1'b0; bif.i_dbus_address = 32'h0000_0040;
    #1;
    chk("t3_idle_req", bif.o_bus_request, 0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge i_clock);
      if (c == 5) bif.i_ibus_request = 1'b1;
      #1;
      chk("t3_req", bif.o_bus_request, 1);
      chk("t3_timeout_pre", bif.o_timeout, 0);
      chk("t3_dready", bif.o_dbus_ready, (c == 8) ? 32'd1 : 32'd0);
      chk("t3_drdata", bif.o_dbus_rdata, 0);
      chk("t3_iready", bif.o_ibus_ready, 0);
    end
    @(negedge i_clock); #1;
    chk("t3_gap_req", bif.o_bus_request, 0);
    chk("t3_timeout_set", bif.o_timeout, 1);
    @(negedge i_clock); #1;
    chk("t3_next_req", bif.o_bus_request, 1);
    chk("t3_next_addr", bif.o_bus_address, 32'h0000_3000);
    chk("t3_next_rw", bif.o_bus_rw, 0);
    @(negedge i_clock); bif.i_bus_ready = 1'b1; bif.i_bus_rdata = 32'h2222_2222; #1;
    chk("t3_next_iready", bif.o_ibus_ready, 1);
    chk("t3_next_irdata", bif.o_ibus_rdata, 32'h2222_2222);
    @(negedge i_clock);
    bif.i_bus_ready = 1'b0; bif.i_bus_rdata = '0;
    bif.i_ibus_request = 1'b0; bif.i_dbus_request = 1'b0;
    #1;
    chk("t3_timeout_sticky", bif.o_timeout, 1);

    // T4: ready on the expiry cycle wins; timeout stays clear
    @(negedge i_clock); i_reset = 1'b0; #1;
    chk("t4_rst_timeout", bif.o_timeout, 0);
    @(negedge i_clock); i_reset = 1'b1; bif.i_ibus_request = 1'b1; bif.i_ibus_address = 32'h0000_4000;
    for (int c = 1; c <= 8; c++) begin
      @(negedge i_clock);
      if (c == 8) begin bif.i_bus_ready = 1'b1; bif.i_bus_rdata = 32'h1234_5678; end
      #1;
      chk("t4_iready", bif.o_ibus_ready, (c == 8) ? 32'd1 : 32'd0);
      chk("t4_irdata", bif.o_ibus_rdata, (c == 8) ? 32'h1234_5678 : 32'h0);
    end
    @(negedge i_clock); bif.i_bus_ready = 1'b0; bif.i_bus_rdata = '0; bif.i_ibus_request = 1'b0; #1;
    chk("t4_timeout", bif.o_timeout, 0);

    // T5: asynchronous reset two cycles into a D write
    @(negedge i_clock);
    bif.i_dbus_request = 1'b1; bif.i_dbus_rw = 1'b1;
    bif.i_dbus_address = 32'h0000_0050; bif.i_dbus_wdata = 32'hCAFE_F00D;
    #1;
    chk("t5_idle_req", bif.o_bus_request, 0);
    @(negedge i_clock); #1;
    chk("t5_g1_req", bif.o_bus_request, 1);
    @(negedge i_clock); #1;
    chk("t5_g2_req", bif.o_bus_request, 1);
    #1 bif.i_bus_ready = 1'b1;
    #1;
    chk("t5_g2_dready", bif.o_dbus_ready, 1);
    i_reset = 1'b0;
    #1;
    chk("t5_rst_req", bif.o_bus_request, 0);
    chk("t5_rst_dready", bif.o_dbus_ready, 0);
    chk("t5_rst_iready", bif.o_ibus_ready, 0);
    chk("t5_rst_wdata", bif.o_bus_wdata, 0);
    @(negedge i_clock);
    bif.i_bus_ready = 1'b0; i_reset = 1'b1;
    bif.i_ibus_request = 1'b1; bif.i_ibus_address = 32'h0000_5000;
    #1;
    chk("t5_rel_req", bif.o_bus_request, 0);
    @(negedge i_clock); #1;
    chk("t5_first_addr", bif.o_bus_address, 32'h0000_5000);
    chk("t5_first_rw", bif.o_bus_rw, 0);
    @(negedge i_clock); bif.i_bus_ready = 1'b1; bif.i_bus_rdata = 32'h3333_3333; #1;
    chk("t5_first_iready", bif.o_ibus_ready, 1);
    @(negedge i_clock);
    bif.i_bus_ready = 1'b0; bif.i_bus_rdata = '0;
    bif.i_ibus_request = 1'b0; bif.i_dbus_request = 1'b0;

    // T6: D aborts while granted; no ready, back to IDLE
    @(negedge i_clock);
    bif.i_dbus_request = 1'b1; bif.i_dbus_rw = 1'b0; bif.i_dbus_address = 32'h0000_0060;
    #1;
    chk("t6_idle_req", bif.o_bus_request, 0);
    @(negedge i_clock); #1;
    chk("t6_g1_req", bif.o_bus_request, 1);
    @(negedge i_clock); bif.i_dbus_request = 1'b0; #1;
    chk("t6_abort_req", bif.o_bus_request, 0);
    chk("t6_abort_dready", bif.o_dbus_ready, 0);
    chk("t6_abort_iready", bif.o_ibus_ready, 0);
    @(negedge i_clock); #1;
    chk("t6_post_dready", bif.o_dbus_ready, 0);
    chk("t6_post_iready", bif.o_ibus_ready, 0);
    @(negedge i_clock); bif.i_dbus_request = 1'b1; #1;
    chk("t6_reidle_req", bif.o_bus_request, 0);
    @(negedge i_clock); #1;
    chk("t6_regrant_req", bif.o_bus_request, 1);
    @(negedge i_clock); bif.i_bus_ready = 1'b1; bif.i_bus_rdata = 32'h4444_4444; #1;
    chk("t6_dready", bif.o_dbus_ready, 1);
    chk("t6_drdata", bif.o_dbus_rdata, 32'h4444_4444);
    @(negedge i_clock); bif.i_bus_ready = 1'b0; bif.i_bus_rdata = '0; bif.i_dbus_request = 1'b0;
    chk("t6_end_timeout", bif.o_timeout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
